// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 five-stage pipeline control: stall/bubble generation, next-PC select, ret tracking, sticky halt.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       w_stat,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             w_stall,
  output logic [1:0]       pc_sel,
  output logic             halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic [1:0] {IDLE, RET_E, RET_M, RET_W} ret_state_e;

  ret_state_e state_q, state_d;
  logic       halted_q, halted_d;
  logic       lu, mp, retq, exc_m, exc_w, ret_go;

  always_comb begin
    lu    = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) && (e_dstM != R_NONE) &&
            ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    mp    = (e_icode == I_JXX) && !e_cnd;
    retq  = (d_icode == I_RET) || (state_q == RET_E) || (state_q == RET_M);
    exc_m = (m_stat != 2'd0);
    exc_w = (w_stat != 2'd0);
    // a ret held by load-use or squashed by a mispredict does not start the sequence
    ret_go = (d_icode == I_RET) && !lu && !mp;
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q | exc_w;
    if (halted_q || exc_w) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ret_go ? RET_E : IDLE;
        RET_E:   state_d = RET_M;
        RET_M:   state_d = RET_W;
        RET_W:   state_d = ret_go ? RET_E : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b1;
    e_bubble = 1'b1;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    pc_sel   = 2'd0;
    halted   = 1'b0;
    if (rst_n) begin
      if (halted_q) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        m_bubble = 1'b1;
        w_stall  = 1'b1;
        halted   = 1'b1;
      end else begin
        f_stall  = lu | retq;
        d_stall  = lu;
        d_bubble = mp | (retq & !lu);
        e_bubble = mp | lu;
        m_bubble = exc_m | exc_w;
        w_stall  = exc_w;
        if ((m_icode == I_JXX) && !m_cnd) pc_sel = 2'd1;
        else if (state_q == RET_W)        pc_sel = 2'd2;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, lu_cnt_q, mp_cnt_q, ret_cnt_q;
  logic [CNT_W-1:0] cyc_cnt_d, lu_cnt_d, mp_cnt_d, ret_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    lu_cnt_d  = lu_cnt_q;
    mp_cnt_d  = mp_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (!halted_q) begin
      cyc_cnt_d = sat_inc(cyc_cnt_q, 1'b1);
      lu_cnt_d  = sat_inc(lu_cnt_q, lu);
      mp_cnt_d  = sat_inc(mp_cnt_q, mp);
      ret_cnt_d = sat_inc(ret_cnt_q, retq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, then random stimulus against a cycle-level model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode;
  logic       e_cnd, m_cnd;
  logic [1:0] m_stat, w_stat;
  logic       f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, halted;
  logic [1:0] pc_sel;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_stat(m_stat), .w_stat(w_stat),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .m_bubble(m_bubble), .w_stall(w_stall), .pc_sel(pc_sel), .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // exp layout: {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, pc_sel[1:0], halted}
  typedef struct {
    logic       rst_n;
    logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstM;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic       m_cnd;
    logic [1:0] m_stat, w_stat;
    logic [8:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: ret_age 0 = no ret in flight, 1/2/3 = ret in E/M/W
  int       ret_age;
  logic     m_halted;
  longint   c_cyc, c_lu, c_mp, c_ret;

  function automatic vec_t nop_vec();
    vec_t v;
    v.rst_n = 1'b1; v.d_icode = 4'h1; v.d_srcA = 4'hF; v.d_srcB = 4'hF;
    v.e_icode = 4'h1; v.e_dstM = 4'hF; v.e_cnd = 1'b1;
    v.m_icode = 4'h1; v.m_cnd = 1'b1; v.m_stat = 2'd0; v.w_stat = 2'd0;
    v.exp = 9'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; d_icode = v.d_icode; d_srcA = v.d_srcA; d_srcB = v.d_srcB;
    e_icode = v.e_icode; e_dstM = v.e_dstM; e_cnd = v.e_cnd;
    m_icode = v.m_icode; m_cnd = v.m_cnd; m_stat = v.m_stat; w_stat = v.w_stat;
  endtask

  function automatic logic [8:0] actual();
    return {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, pc_sel, halted};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (f ds db eb mb ws pc[2] h)", name, act, exp);
    end
  endtask

  function automatic bit is_lu(input vec_t v);
    return (v.e_icode == 4'd5 || v.e_icode == 4'd11) && v.e_dstM != 4'd15 &&
           (v.e_dstM == v.d_srcA || v.e_dstM == v.d_srcB);
  endfunction

  function automatic bit is_mp(input vec_t v);
    return v.e_icode == 4'd7 && v.e_cnd == 1'b0;
  endfunction

  function automatic logic [8:0] model_out(input vec_t v);
    bit lu, mp, retq, em, ew;
    int pc;
    if (!v.rst_n) return 9'b001100000;
    if (m_halted) return 9'b111111001;
    lu   = is_lu(v);
    mp   = is_mp(v);
    retq = (v.d_icode == 4'd9) || ret_age == 1 || ret_age == 2;
    em   = v.m_stat != 0;
    ew   = v.w_stat != 0;
    if (v.m_icode == 4'd7 && !v.m_cnd) pc = 1;
    else if (ret_age == 3)             pc = 2;
    else                               pc = 0;
    return {lu | retq, lu, mp | (retq & !lu), mp | lu, em | ew, ew, 2'(pc), 1'b0};
  endfunction

  function automatic longint sat(input longint c, input bit en);
    longint lim;
    lim = (64'd1 << CNT_W) - 1;
    return (en && c < lim) ? c + 1 : c;
  endfunction

  task automatic model_step(input vec_t v);
    bit lu, mp, retq;
    if (!v.rst_n) begin
      ret_age = 0; m_halted = 1'b0;
      c_cyc = 0; c_lu = 0; c_mp = 0; c_ret = 0;
      return;
    end
    lu   = is_lu(v);
    mp   = is_mp(v);
    retq = (v.d_icode == 4'd9) || ret_age == 1 || ret_age == 2;
    if (!m_halted) begin
      c_cyc = sat(c_cyc, 1'b1);
      c_lu  = sat(c_lu, lu);
      c_mp  = sat(c_mp, mp);
      c_ret = sat(c_ret, retq);
    end
    if (m_halted || v.w_stat != 0) ret_age = 0;
    else if (ret_age == 1 || ret_age == 2) ret_age = ret_age + 1;
    else ret_age = (v.d_icode == 4'd9 && !lu && !mp) ? 1 : 0;
    if (v.w_stat != 0) m_halted = 1'b1;
  endtask

  vec_t tbl[$];

  task automatic add(input vec_t v, input logic [8:0] exp);
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v, n;
    apply(nop_vec());
    rst_n = 1'b0;
    ret_age = 0; m_halted = 1'b0; c_cyc = 0; c_lu = 0; c_mp = 0; c_ret = 0;

    n = nop_vec();
    // reset held two cycles while a ret and a load sit in D/E
    v = n; v.rst_n = 0; v.d_icode = 9; v.e_icode = 5; v.e_dstM = 3; v.d_srcA = 3;
    add(v, 9'b001100000); add(v, 9'b001100000);
    v = n; v.e_icode = 5; v.e_dstM = 3; v.d_srcA = 3;   add(v, 9'b110100000);
    v.e_dstM = 4'hF;                                    add(v, 9'b000000000);
    v = n; v.e_icode = 4'hB; v.e_dstM = 4; v.d_srcB = 4; add(v, 9'b110100000);
    v = n; v.e_icode = 7; v.e_cnd = 0;                  add(v, 9'b001100000);
    v = n; v.m_icode = 7; v.m_cnd = 0;                  add(v, 9'b000000010);
    // single ret
    v = n; v.d_icode = 9;                               add(v, 9'b101000000);
    add(n, 9'b101000000); add(n, 9'b101000000); add(n, 9'b000000100); add(n, 9'b000000000);
    // ret squashed by mispredict
    v = n; v.d_icode = 9; v.e_icode = 7; v.e_cnd = 0;   add(v, 9'b101100000);
    add(n, 9'b0); add(n, 9'b0); add(n, 9'b0);
    // ret held by load-use, then released, then back-to-back ret from RET_W
    v = n; v.d_icode = 9; v.e_icode = 5; v.e_dstM = 2; v.d_srcA = 2; add(v, 9'b110100000);
    v = n; v.d_icode = 9;                               add(v, 9'b101000000);
    add(n, 9'b101000000); add(n, 9'b101000000);
    v = n; v.d_icode = 9;                               add(v, 9'b101000100);
    add(n, 9'b101000000); add(n, 9'b101000000); add(n, 9'b000000100); add(n, 9'b0);
    // exception retiring, halt, reset release
    v = n; v.m_stat = 2;                                add(v, 9'b000010000);
    v.w_stat = 2;                                       add(v, 9'b000011000);
    v = n; v.w_stat = 2;                                add(v, 9'b111111001);
    v = n; v.m_icode = 7; v.m_cnd = 0;                  add(v, 9'b111111001);
    v = n; v.rst_n = 0;                                 add(v, 9'b001100000);
    add(n, 9'b0);
    // exception during ret
    v = n; v.d_icode = 9;                               add(v, 9'b101000000);
    v = n; v.w_stat = 1;                                add(v, 9'b101011000);
    add(n, 9'b111111001);
    v = n; v.rst_n = 0;                                 add(v, 9'b001100000);
    add(n, 9'b0);
    // reset in the middle of a ret
    v = n; v.d_icode = 9;                               add(v, 9'b101000000);
    v = n; v.rst_n = 0;                                 add(v, 9'b001100000);
    add(n, 9'b0); add(n, 9'b0); add(n, 9'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), actual(), tbl[i].exp);
      check($sformatf("vec%0d_model", i), model_out(tbl[i]), tbl[i].exp);
      model_step(tbl[i]);
    end

    // random stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      v.rst_n   = ($urandom_range(0, 49) != 0);
      v.d_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      v.d_srcA  = 4'($urandom_range(0, 15));
      v.d_srcB  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       v.e_icode = 4'd5;
        1:       v.e_icode = 4'd11;
        2:       v.e_icode = 4'd7;
        default: v.e_icode = 4'($urandom_range(0, 15));
      endcase
      v.e_dstM  = ($urandom_range(0, 1) == 0) ? v.d_srcA : 4'($urandom_range(0, 15));
      v.e_cnd   = 1'($urandom_range(0, 1));
      v.m_icode = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      v.m_cnd   = 1'($urandom_range(0, 1));
      v.m_stat  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.w_stat  = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      @(negedge clk);
      apply(v);
      #1;
      check($sformatf("rand%0d", i), actual(), model_out(v));
      model_step(v);
    end

`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    n_checks++;
    if (cyc_cnt !== CNT_W'(c_cyc) || lu_cnt !== CNT_W'(c_lu) ||
        mp_cnt !== CNT_W'(c_mp) || ret_cnt !== CNT_W'(c_ret)) begin
      n_fail++;
      $display("FAIL perf_cnt: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               cyc_cnt, lu_cnt, mp_cnt, ret_cnt, c_cyc, c_lu, c_mp, c_ret);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
